// File: rtl/rpn_stack_ctrl.sv
// rpn_stack_ctrl: reverse-Polish token controller for an 8-deep stack.
// Operands are pushed. An operator pops b (the top) and then a, and pushes
// the result of a <op> b. Occupancy is tracked here, so an overflow or an
// underflow is refused before it reaches the stack and sets a sticky flag.
module rpn_stack_ctrl #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tok_valid,
   output logic              tok_ready,
   input  logic              tok_is_op,
   input  logic [DATA_W-1:0] tok_data,
   input  logic              err_clr,
   output logic              stack_enable,
   output logic              stack_push_pop,
   output logic [DATA_W-1:0] stack_data_in,
   input  logic [DATA_W-1:0] stack_data_out,
   output logic [CNT_W-1:0]  depth,
   output logic              res_valid,
   output logic [DATA_W-1:0] res_data,
   output logic              err_overflow,
   output logic              err_underflow
);

   typedef enum logic [2:0] {
      IDLE,
      PUSH,
      POP_B,
      POP_A,
      CAP_A,
      PUSH_R
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] opnd;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [DATA_W-1:0] result;
   logic [1:0]        opcode;
   logic [DATA_W-1:0] alu;

   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] TWO  = CNT_W'(2);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   // Operator datapath on the captured operands; wraps modulo 2^DATA_W.
   always_comb begin
      alu = '0;
      case (opcode)
         2'b00:   alu = a + b;
         2'b01:   alu = a - b;
         2'b10:   alu = a & b;
         default: alu = a ^ b;
      endcase
   end

   // Token sequencing, occupancy tracking, operand capture and error flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         depth         <= '0;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
         opnd          <= '0;
         a             <= '0;
         b             <= '0;
         result        <= '0;
         opcode        <= '0;
      end else begin
         // A clear is overridden by an error raised in the same cycle below.
         if (err_clr) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (tok_valid) begin
                  if (!tok_is_op) begin
                     if (depth < FULL) begin
                        opnd  <= tok_data;
                        state <= PUSH;
                     end else begin
                        err_overflow <= 1'b1;
                     end
                  end else begin
                     if (depth >= TWO) begin
                        opcode <= tok_data[1:0];
                        state  <= POP_B;
                     end else begin
                        err_underflow <= 1'b1;
                     end
                  end
               end
            end
            PUSH: begin
               depth <= depth + ONE;
               state <= IDLE;
            end
            POP_B: begin
               depth <= depth - ONE;
               state <= POP_A;
            end
            POP_A: begin
               b     <= stack_data_out;
               depth <= depth - ONE;
               state <= CAP_A;
            end
            CAP_A: begin
               a     <= stack_data_out;
               state <= PUSH_R;
            end
            PUSH_R: begin
               result <= alu;
               depth  <= depth + ONE;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Stack command and handshake decode, purely from the current state.
   always_comb begin
      tok_ready      = (state == IDLE);
      stack_enable   = (state == PUSH) || (state == POP_B) ||
                       (state == POP_A) || (state == PUSH_R);
      stack_push_pop = (state == PUSH) || (state == PUSH_R);
      res_valid      = (state == PUSH_R);
      stack_data_in  = '0;
      if (state == PUSH)
         stack_data_in = opnd;
      else if (state == PUSH_R)
         stack_data_in = alu;
   end

   // The result is presented live during PUSH_R and is held in 'result' after.
   always_comb begin
      res_data = (state == PUSH_R) ? alu : result;
   end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Testbench for rpn_stack_ctrl: a behavioural 8-deep stack answers the DUT's
// stack port, and a queue-based RPN evaluator predicts results, occupancy and
// error flags.
module tb_rpn_stack_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tok_valid = 1'b0;
   logic       tok_ready;
   logic       tok_is_op = 1'b0;
   logic [7:0] tok_data = '0;
   logic       err_clr = 1'b0;
   logic       stack_enable;
   logic       stack_push_pop;
   logic [7:0] stack_data_in;
   logic [7:0] stack_data_out;
   logic [3:0] depth;
   logic       res_valid;
   logic [7:0] res_data;
   logic       err_overflow;
   logic       err_underflow;

   int tests = 0;
   int fails = 0;

   rpn_stack_ctrl #(.DATA_W(8), .DEPTH(8), .CNT_W(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .tok_valid      (tok_valid),
      .tok_ready      (tok_ready),
      .tok_is_op      (tok_is_op),
      .tok_data       (tok_data),
      .err_clr        (err_clr),
      .stack_enable   (stack_enable),
      .stack_push_pop (stack_push_pop),
      .stack_data_in  (stack_data_in),
      .stack_data_out (stack_data_out),
      .depth          (depth),
      .res_valid      (res_valid),
      .res_data       (res_data),
      .err_overflow   (err_overflow),
      .err_underflow  (err_underflow)
   );

   always #5 clk = ~clk;

   // Behavioural stack: pop data appears on data_out the cycle after the pop.
   logic [7:0] smem [0:7];
   int         sp = 0;
   int         stk_bad = 0;
   logic [7:0] sdo = '0;
   assign stack_data_out = sdo;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         sp  <= 0;
         sdo <= '0;
      end else if (stack_enable) begin
         if (stack_push_pop) begin
            if (sp >= 8) stk_bad <= stk_bad + 1;
            else begin
               smem[sp] <= stack_data_in;
               sp <= sp + 1;
            end
         end else begin
            if (sp <= 0) stk_bad <= stk_bad + 1;
            else begin
               sdo <= smem[sp-1];
               sp <= sp - 1;
            end
         end
      end
   end

   // Reference RPN evaluator
   logic [7:0] q[$];
   bit         ref_ovf = 0;
   bit         ref_unf = 0;

   task automatic ref_token(input bit is_op, input logic [7:0] d,
                            output bit has, output logic [7:0] r);
      logic [7:0] x, y;
      has = 0;
      r = '0;
      if (!is_op) begin
         if (q.size() < 8) q.push_back(d);
         else ref_ovf = 1;
      end else if (q.size() >= 2) begin
         y = q.pop_back();
         x = q.pop_back();
         case (d[1:0])
            2'b00: r = x + y;
            2'b01: r = x - y;
            2'b10: r = x & y;
            default: r = x ^ y;
         endcase
         q.push_back(r);
         has = 1;
      end else begin
         ref_unf = 1;
      end
   endtask

   task automatic do_reset();
      tok_valid = 0;
      err_clr = 0;
      reset = 1;
      @(posedge clk);
      @(negedge clk);
      reset = 0;
      q.delete();
      ref_ovf = 0;
      ref_unf = 0;
   endtask

   // Present one token, then follow the DUT until it is ready again. Cycle 1
   // is the accept cycle; rcyc is the cycle in which res_valid was seen.
   task automatic do_token(input bit is_op, input logic [7:0] d,
                           output int nres, output logic [7:0] rdata,
                           output int rcyc, output int en_cnt);
      int w;
      int c;
      nres = 0;
      rdata = '0;
      rcyc = 0;
      en_cnt = 0;
      w = 0;
      while (!tok_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      tests++;
      if (!tok_ready) begin
         fails++;
         $display("FAIL ready_wait: tok_ready=%b required 1", tok_ready);
         return;
      end
      tok_valid = 1;
      tok_is_op = is_op;
      tok_data = d;
      @(negedge clk);
      tok_valid = 0;
      tok_data = 8'($urandom);
      c = 2;
      for (int k = 0; k < 20; k++) begin
         if (res_valid) begin
            nres++;
            rdata = res_data;
            rcyc = c;
         end
         if (stack_enable) en_cnt++;
         if (tok_ready) break;
         @(negedge clk);
         c++;
      end
      tests++;
      if (!tok_ready) begin
         fails++;
         $display("FAIL token_done: tok_ready=%b required 1", tok_ready);
      end
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if ({tok_ready, depth, res_valid, res_data} !== {1'b1, 4'd0, 1'b0, 8'h00}) begin
         fails++;
         $display("FAIL reset_status: got %b required %b",
                  {tok_ready, depth, res_valid, res_data}, {1'b1, 4'd0, 1'b0, 8'h00});
      end
      tests++;
      if ({stack_enable, stack_push_pop, stack_data_in, err_overflow, err_underflow} !== 12'h000) begin
         fails++;
         $display("FAIL reset_stack_err: got %h required 000",
                  {stack_enable, stack_push_pop, stack_data_in, err_overflow, err_underflow});
      end
   endtask

   task automatic test_add();
      int n, rc, en;
      logic [7:0] rd;
      do_reset();
      do_token(0, 8'd3, n, rd, rc, en);
      tests++;
      if (en !== 1) begin fails++; $display("FAIL add_push_en: got %0d required 1", en); end
      do_token(0, 8'd5, n, rd, rc, en);
      do_token(1, 8'h00, n, rd, rc, en);
      tests++;
      if (n !== 1 || rd !== 8'd8) begin
         fails++;
         $display("FAIL add_result: got n=%0d data=%h required n=1 data=08", n, rd);
      end
      tests++;
      if (rc !== 5) begin fails++; $display("FAIL add_latency: got %0d required 5", rc); end
      tests++;
      if (depth !== 4'd1 || sp !== 1 || smem[0] !== 8'd8) begin
         fails++;
         $display("FAIL add_stack: got depth=%0d sp=%0d top=%h required 1 1 08", depth, sp, smem[0]);
      end
   endtask

   task automatic test_sub_and();
      int n, rc, en;
      logic [7:0] rd;
      do_reset();
      do_token(0, 8'd5, n, rd, rc, en);
      do_token(0, 8'd7, n, rd, rc, en);
      do_token(1, 8'h01, n, rd, rc, en);
      tests++;
      if (n !== 1 || rd !== 8'hFE) begin
         fails++;
         $display("FAIL sub_result: got n=%0d data=%h required n=1 data=fe", n, rd);
      end
      do_token(0, 8'h0F, n, rd, rc, en);
      do_token(1, 8'h02, n, rd, rc, en);
      tests++;
      if (n !== 1 || rd !== 8'h0E || depth !== 4'd1) begin
         fails++;
         $display("FAIL and_result: got n=%0d data=%h depth=%0d required 1 0e 1", n, rd, depth);
      end
      tests++;
      if (res_data !== 8'h0E) begin
         fails++;
         $display("FAIL res_hold: got %h required 0e", res_data);
      end
   endtask

   task automatic test_overflow();
      int n, rc, en;
      logic [7:0] rd;
      do_reset();
      for (int i = 1; i <= 9; i++) do_token(0, 8'(i), n, rd, rc, en);
      tests++;
      if (depth !== 4'd8 || err_overflow !== 1'b1 || en !== 0 || sp !== 8) begin
         fails++;
         $display("FAIL overflow: got depth=%0d ovf=%b en=%0d sp=%0d required 8 1 0 8",
                  depth, err_overflow, en, sp);
      end
      err_clr = 1;
      @(negedge clk);
      err_clr = 0;
      tests++;
      if (err_overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b required 0", err_overflow); end
      // clear and a fresh overflow in the same cycle: the error must win
      tok_valid = 1; tok_is_op = 0; tok_data = 8'hAA; err_clr = 1;
      @(negedge clk);
      tok_valid = 0; err_clr = 0;
      tests++;
      if (err_overflow !== 1'b1 || depth !== 4'd8) begin
         fails++;
         $display("FAIL ovf_clr_race: got ovf=%b depth=%0d required 1 8", err_overflow, depth);
      end
      tests++;
      if (smem[7] !== 8'd8) begin fails++; $display("FAIL ovf_top: got %h required 08", smem[7]); end
   endtask

   task automatic test_underflow();
      int n, rc, en;
      logic [7:0] rd;
      do_reset();
      do_token(0, 8'd4, n, rd, rc, en);
      do_token(1, 8'h03, n, rd, rc, en);
      tests++;
      if (err_underflow !== 1'b1 || depth !== 4'd1 || en !== 0 || n !== 0) begin
         fails++;
         $display("FAIL underflow: got unf=%b depth=%0d en=%0d n=%0d required 1 1 0 0",
                  err_underflow, depth, en, n);
      end
      do_token(0, 8'd6, n, rd, rc, en);
      do_token(1, 8'h03, n, rd, rc, en);
      tests++;
      if (n !== 1 || rd !== 8'h02 || err_overflow !== 1'b0) begin
         fails++;
         $display("FAIL xor_result: got n=%0d data=%h ovf=%b required 1 02 0", n, rd, err_overflow);
      end
   endtask

   task automatic test_back_to_back();
      int n, rc, en, rv, rvc, busy;
      logic [7:0] rd, got;
      do_reset();
      do_token(0, 8'd10, n, rd, rc, en);
      do_token(0, 8'd20, n, rd, rc, en);
      tok_valid = 1; tok_is_op = 1; tok_data = 8'h00;
      rv = 0; rvc = 0; busy = 0; got = '0;
      for (int c = 2; c <= 5; c++) begin
         @(negedge clk);
         if (!tok_ready) busy++;
         if (res_valid) begin rv++; rvc = c; got = res_data; end
      end
      @(negedge clk);
      tests++;
      if (busy !== 4 || rv !== 1 || rvc !== 5 || got !== 8'd30) begin
         fails++;
         $display("FAIL held_op: got busy=%0d pulses=%0d cyc=%0d data=%h required 4 1 5 1e",
                  busy, rv, rvc, got);
      end
      tests++;
      if (tok_ready !== 1'b1 || res_valid !== 1'b0) begin
         fails++;
         $display("FAIL held_idle: got ready=%b res_valid=%b required 1 0", tok_ready, res_valid);
      end
      tok_is_op = 0; tok_data = 8'h33;
      @(negedge clk);
      tests++;
      if (tok_ready !== 1'b0 || stack_enable !== 1'b1) begin
         fails++;
         $display("FAIL held_follow: got ready=%b en=%b required 0 1", tok_ready, stack_enable);
      end
      tok_valid = 0;
      @(negedge clk);
      tests++;
      if (depth !== 4'd2 || sp !== 2 || smem[1] !== 8'h33 || smem[0] !== 8'd30) begin
         fails++;
         $display("FAIL held_stack: got depth=%0d sp=%0d s1=%h s0=%h required 2 2 33 1e",
                  depth, sp, smem[1], smem[0]);
      end
   endtask

   task automatic test_reset_mid();
      int n, rc, en;
      logic [7:0] rd;
      do_reset();
      do_token(0, 8'd1, n, rd, rc, en);
      do_token(0, 8'd2, n, rd, rc, en);
      tok_valid = 1; tok_is_op = 1; tok_data = 8'h00;
      @(negedge clk);
      tok_valid = 0;
      @(negedge clk);
      tests++;
      if (stack_enable !== 1'b1 || stack_push_pop !== 1'b0) begin
         fails++;
         $display("FAIL mid_pop: got en=%b pp=%b required 1 0", stack_enable, stack_push_pop);
      end
      reset = 1;
      #1;
      tests++;
      if ({tok_ready, depth, res_valid, stack_enable, stack_push_pop, stack_data_in} !== {1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
         fails++;
         $display("FAIL mid_reset: got %b required %b",
                  {tok_ready, depth, res_valid, stack_enable, stack_push_pop, stack_data_in},
                  {1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00});
      end
      @(posedge clk);
      @(negedge clk);
      reset = 0;
      q.delete();
      do_token(0, 8'h11, n, rd, rc, en);
      tests++;
      if (en !== 1 || depth !== 4'd1 || sp !== 1 || smem[0] !== 8'h11) begin
         fails++;
         $display("FAIL mid_after: got en=%0d depth=%0d sp=%0d top=%h required 1 1 1 11",
                  en, depth, sp, smem[0]);
      end
   endtask

   task automatic test_random();
      int n, rc, en, pct;
      logic [7:0] rd, r, d;
      bit op, has;
      do_reset();
      for (int i = 0; i < 360; i++) begin
         pct = (i < 120) ? 25 : (i < 240) ? 70 : 45;
         op = ($urandom_range(99) < pct);
         d = 8'($urandom);
         if (i % 60 == 59) begin
            err_clr = 1;
            @(negedge clk);
            err_clr = 0;
            ref_ovf = 0;
            ref_unf = 0;
         end
         ref_token(op, d, has, r);
         do_token(op, d, n, rd, rc, en);
         tests++;
         if (has ? (n !== 1 || rd !== r || rc !== 5) : (n !== 0)) begin
            fails++;
            $display("FAIL rand_result[%0d]: got n=%0d data=%h cyc=%0d required n=%0d data=%h",
                     i, n, rd, rc, has, r);
         end
         tests++;
         if (depth !== 4'(q.size()) || {err_overflow, err_underflow} !== {ref_ovf, ref_unf}) begin
            fails++;
            $display("FAIL rand_state[%0d]: got depth=%0d ovf=%b unf=%b required %0d %b %b",
                     i, depth, err_overflow, err_underflow, q.size(), ref_ovf, ref_unf);
         end
         if (q.size() > 0) begin
            tests++;
            if (sp !== q.size() || smem[sp-1] !== q[$]) begin
               fails++;
               $display("FAIL rand_top[%0d]: got sp=%0d top=%h required %0d %h",
                        i, sp, smem[sp-1], q.size(), q[$]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_and();
      test_overflow();
      test_underflow();
      test_back_to_back();
      test_reset_mid();
      test_random();
      tests++;
      if (stk_bad !== 0) begin
         fails++;
         $display("FAIL stack_bounds: got %0d illegal stack ops required 0", stk_bad);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rpn_stack_ctrl.md
Name: rpn_stack_ctrl

Overview:
- Token-driven controller that sits directly upstream of the 8-deep, 8-bit stack block and drives its enable/push_pop/data_in port.
- It evaluates reverse-Polish expressions. An operand token is pushed; an operator token pops two values, computes, and pushes the result.
- Tracks stack occupancy internally, blocks overflow/underflow before they reach the stack, and reports each result plus sticky error flags.

Parameters:
- DATA_W, 8, width of operands, results and the stack data bus.
- DEPTH, 8, stack capacity in entries; must equal the attached stack's depth.
- CNT_W, 4, occupancy counter width; must hold 0..DEPTH.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high; shared with the attached stack.
- tok_valid  input  1  token present.
- tok_ready  output  1  controller can accept a token.
- tok_is_op  input  1  1 = operator token, 0 = operand token.
- tok_data  input  DATA_W  operand value, or opcode in bits [1:0] when tok_is_op=1.
- err_clr  input  1  synchronous clear of both error flags.
- stack_enable  output  1  to stack enable.
- stack_push_pop  output  1  to stack push_pop; 1 = push, 0 = pop.
- stack_data_in  output  DATA_W  to stack data_in.
- stack_data_out  input  DATA_W  from stack data_out; popped value is valid the cycle after the pop cycle.
- depth  output  CNT_W  current stack occupancy.
- res_valid  output  1  one-cycle pulse when an operator result is pushed.
- res_data  output  DATA_W  result value, valid while res_valid=1.
- err_overflow  output  1  sticky: operand dropped because the stack was full.
- err_underflow  output  1  sticky: operator dropped because depth < 2.

Behaviour:
- Reset values:
  - State IDLE, depth=0, both error flags 0.
  - res_valid=0, res_data=0, stack_enable=0, stack_push_pop=0, stack_data_in=0.
  - Internal registers opnd, a, b and result = 0.
- FSM states: IDLE, PUSH, POP_B, POP_A, CAP_A, PUSH_R.
- Output decode:
  - stack_* outputs and tok_ready decode from state only (Moore).
  - tok_ready=1 only in IDLE.
  - stack_enable=1 only in PUSH, POP_B, POP_A and PUSH_R.
- IDLE, operand accept (tok_valid & tok_is_op=0):
  - depth<DEPTH: latch opnd=tok_data, go to PUSH.
  - depth==DEPTH: set err_overflow, drop the token, stay in IDLE.
- IDLE, operator accept (tok_valid & tok_is_op=1):
  - depth>=2: latch opcode=tok_data[1:0], go to POP_B.
  - Otherwise: set err_underflow, drop the token, stay in IDLE. No stack activity.
- PUSH: stack_push_pop=1, stack_data_in=opnd, depth+1, go to IDLE.
- POP_B: stack_push_pop=0, depth-1, go to POP_A.
- POP_A: capture b=stack_data_out, issue a pop (push_pop=0), depth-1, go to CAP_A.
- CAP_A: capture a=stack_data_out, compute result, no stack activity, go to PUSH_R.
- Opcodes (a = older entry, b = former top):
  - 00: a+b mod 2^DATA_W.
  - 01: a-b mod 2^DATA_W.
  - 10: a&b.
  - 11: a^b.
  - No carry or borrow output.
- PUSH_R:
  - stack_push_pop=1, stack_data_in=result, depth+1.
  - res_valid=1, res_data=result; res_data holds its value afterwards.
  - Go to IDLE.
- Latency and throughput:
  - Operand: 2 cycles, accept to push.
  - Operator: 5 cycles, accept to result pulse.
  - Next token can be accepted the cycle after PUSH or PUSH_R.
- Handshake:
  - Token transfers on tok_valid & tok_ready.
  - tok_valid held high while not ready causes no side effects.
  - Each token is consumed exactly once.
- Depth bounds: depth never exceeds DEPTH and never goes below 0. An operator nets -1. The stack is never pushed when full or popped when empty.
- Error flags:
  - Sticky until reset or err_clr.
  - If err_clr and a new error occur in the same cycle, the new error wins (flag reads 1).
  - Errors never stall the FSM.
- Reset mid-operation: asynchronous return to reset values. Any partial operation is abandoned with no further stack commands; the stack is reset by the same signal.

Test Plan:
- Push 3, push 5, operator 00 -> one res_valid pulse with res_data=8, 5 cycles after operator accept; depth=1; stack top=8.
- Push 5, push 7, operator 01 -> res_data=0xFE; then push 0x0F, operator 10 -> res_data=0x0E, depth=1.
- Push 9 operands 1..9 -> depth=8, err_overflow=1 on 9th, stack_enable stays 0 for it; err_clr -> flag 0.
- Push 4, operator 11 -> err_underflow=1, depth=1, no pop issued, res_valid stays 0; then push 6, operator 11 -> res_data=0x02.
- tok_valid held high with operator during the full sequence -> tok_ready low from POP_B to PUSH_R; exactly one result; a held follow-on token is accepted once, in the next IDLE cycle.
- Assert reset during POP_A -> all outputs at reset values immediately, depth=0, FSM in IDLE; next push of 0x11 is accepted normally.
